// File: rtl/framebuffer_write.sv
// Row writer: turns a per-row pixel byte stream into byte-lane writes on framebuffer RAM port A.
// Latency: a byte accepted at clock edge N is written during the cycle that follows edge N.
// Backpressure: data_ready (= busy) is high only while a row is being received; bytes seen in IDLE are dropped.
module framebuffer_write #(
    parameter int PIXEL_WIDTH      = 64,
    parameter int PIXEL_HALFHEIGHT = 16,
    parameter int BYTES_PER_PIXEL  = 2,
    localparam int HALF_BITS   = $clog2(PIXEL_HALFHEIGHT),
    localparam int COL_BITS    = $clog2(PIXEL_WIDTH),
    localparam int LANE_BITS   = $clog2(2 * BYTES_PER_PIXEL),
    localparam int ROW_BITS    = $clog2(2 * PIXEL_HALFHEIGHT),
    localparam int ADDR_A_BITS = HALF_BITS + COL_BITS + LANE_BITS
) (
    input  logic                   clk_in,
    input  logic                   reset,
    input  logic                   row_start,
    input  logic [ROW_BITS-1:0]    row_address,
    input  logic [7:0]             data_in,
    input  logic                   data_valid,
    output logic                   data_ready,
    output logic                   busy,
    output logic                   row_done,
    output logic [ADDR_A_BITS-1:0] ram_address,
    output logic [7:0]             ram_data_out,
    output logic                   ram_write_enable,
    output logic                   ram_clk_enable
);

    // Byte index within a pixel; kept at least one bit wide so single-byte pixels still elaborate.
    localparam int BYTE_BITS = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1;

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_RECEIVE = 1'b1
    } state_t;

    state_t                 r_state;
    logic [HALF_BITS-1:0]   r_half_row;
    logic                   r_half;
    logic [COL_BITS-1:0]    r_col;
    logic [BYTE_BITS-1:0]   r_byte;
    logic                   r_busy;
    logic                   r_row_done;
    logic [ADDR_A_BITS-1:0] r_ram_address;
    logic [7:0]             r_ram_data;
    logic                   r_ram_we;

    logic [LANE_BITS-1:0]   w_lane;
    logic                   w_last_byte;
    logic                   w_pixel_done;

    // Lane inside the port-B word: top half takes the low lanes, bottom half the high lanes,
    // and the first (most significant) byte of a pixel lands in the highest lane of its half.
    always_comb begin
        w_lane       = LANE_BITS'(r_half ? BYTES_PER_PIXEL : 0)
                     + LANE_BITS'(BYTES_PER_PIXEL - 1)
                     - LANE_BITS'(r_byte);
        w_pixel_done = (r_byte == BYTE_BITS'(BYTES_PER_PIXEL - 1));
        w_last_byte  = w_pixel_done && (r_col == COL_BITS'(PIXEL_WIDTH - 1));
    end

    // Row FSM with registered write-port outputs; row_start always takes priority over data.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_half_row    <= '0;
            r_half        <= 1'b0;
            r_col         <= '0;
            r_byte        <= '0;
            r_busy        <= 1'b0;
            r_row_done    <= 1'b0;
            r_ram_address <= '0;
            r_ram_data    <= '0;
            r_ram_we      <= 1'b0;
        end else begin
            r_ram_we   <= 1'b0;
            r_row_done <= 1'b0;
            if (row_start) begin
                // New row (or abort of the current one): any coincident byte is dropped.
                r_state    <= S_RECEIVE;
                r_busy     <= 1'b1;
                r_half_row <= row_address[HALF_BITS-1:0];
                r_half     <= row_address[ROW_BITS-1];
                r_col      <= '0;
                r_byte     <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_busy <= 1'b0;
                    end
                    S_RECEIVE: begin
                        if (data_valid) begin
                            r_ram_address <= {r_half_row, r_col, w_lane};
                            r_ram_data    <= data_in;
                            r_ram_we      <= 1'b1;
                            if (w_last_byte) begin
                                // Leave before the counters could wrap; busy drops with the final write.
                                r_state    <= S_IDLE;
                                r_busy     <= 1'b0;
                                r_row_done <= 1'b1;
                                r_col      <= '0;
                                r_byte     <= '0;
                            end else if (w_pixel_done) begin
                                r_byte <= '0;
                                r_col  <= r_col + COL_BITS'(1);
                            end else begin
                                r_byte <= r_byte + BYTE_BITS'(1);
                            end
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy             = r_busy;
    assign data_ready       = r_busy;
    assign row_done         = r_row_done;
    assign ram_address      = r_ram_address;
    assign ram_data_out     = r_ram_data;
    assign ram_write_enable = r_ram_we;
    assign ram_clk_enable   = r_ram_we;

endmodule

// File: tb/tb_framebuffer_write.sv
// Testbench for framebuffer_write: directed scenarios plus randomized rows against a behavioural model.
// Expected writes are queued by the driver and consumed by an independent write-port monitor.
// Data gaps, aborts, stray bytes and mid-row reset are exercised.
module tb_framebuffer_write;

    localparam int W    = 64;
    localparam int HALF = 16;
    localparam int BPP  = 2;
    localparam int AW   = 12;
    localparam int TOTAL = W * BPP;

    logic          clk_in = 1'b0;
    logic          reset;
    logic          row_start;
    logic [4:0]    row_address;
    logic [7:0]    data_in;
    logic          data_valid;
    logic          data_ready;
    logic          busy;
    logic          row_done;
    logic [AW-1:0] ram_address;
    logic [7:0]    ram_data_out;
    logic          ram_write_enable;
    logic          ram_clk_enable;

    framebuffer_write #(
        .PIXEL_WIDTH      (W),
        .PIXEL_HALFHEIGHT (HALF),
        .BYTES_PER_PIXEL  (BPP)
    ) dut (
        .clk_in           (clk_in),
        .reset            (reset),
        .row_start        (row_start),
        .row_address      (row_address),
        .data_in          (data_in),
        .data_valid       (data_valid),
        .data_ready       (data_ready),
        .busy             (busy),
        .row_done         (row_done),
        .ram_address      (ram_address),
        .ram_data_out     (ram_data_out),
        .ram_write_enable (ram_write_enable),
        .ram_clk_enable   (ram_clk_enable)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    dat;
        logic          done;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Reference model state: is a row open, which full-panel row, how many bytes taken.
    bit   m_active = 0;
    int   m_row    = 0;
    int   m_count  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Byte address of stream byte number cnt of full-panel row `row`, from the panel layout.
    function automatic logic [AW-1:0] model_addr(input int row, input int cnt);
        int col, bidx, lane;
        col  = cnt / BPP;
        bidx = cnt % BPP;
        lane = ((row >= HALF) ? BPP : 0) + (BPP - 1 - bidx);
        return AW'((row % HALF) * W * 2 * BPP + col * 2 * BPP + lane);
    endfunction

    // Drive one cycle of inputs, advance the model across the clock edge, then check busy/ready.
    task automatic step(input bit rs, input int ra, input bit dv, input logic [7:0] d);
        exp_t e;
        row_start   = rs;
        row_address = 5'(ra);
        data_valid  = dv;
        data_in     = d;
        @(posedge clk_in);
        if (reset) begin
            m_active = 0;
        end else if (rs) begin
            m_active = 1;
            m_row    = ra;
            m_count  = 0;
        end else if (m_active && dv) begin
            e.addr = model_addr(m_row, m_count);
            e.dat  = d;
            m_count++;
            e.done = (m_count == TOTAL);
            if (e.done) m_active = 0;
            exp_q.push_back(e);
        end
        #1;
        check("busy", 32'(busy), 32'(m_active));
        check("data_ready", 32'(data_ready), 32'(m_active));
    endtask

    // Write-port monitor: every write must match the next queued expectation, in order.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_in);
            check("clk_enable", 32'(ram_clk_enable), 32'(ram_write_enable));
            if (ram_write_enable === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write at %0t",
                             ram_address, ram_data_out, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(ram_address), 32'(e.addr));
                    check("wr_data", 32'(ram_data_out), 32'(e.dat));
                    check("row_done", 32'(row_done), 32'(e.done));
                end
            end else begin
                check("row_done_idle", 32'(row_done), 32'(0));
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    n_cmp++;
                    n_fail++;
                    $display("FAIL missing_write: no write, expected addr 0x%0h data 0x%0h at %0t",
                             e.addr, e.dat, $time);
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'(0));
        check({tag, "_ready"}, 32'(data_ready), 32'(0));
        check({tag, "_row_done"}, 32'(row_done), 32'(0));
        check({tag, "_addr"}, 32'(ram_address), 32'(0));
        check({tag, "_data"}, 32'(ram_data_out), 32'(0));
        check({tag, "_we"}, 32'(ram_write_enable), 32'(0));
        check({tag, "_ce"}, 32'(ram_clk_enable), 32'(0));
    endtask

    initial begin
        int guard;
        reset       = 1'b1;
        row_start   = 1'b0;
        row_address = '0;
        data_in     = '0;
        data_valid  = 1'b0;
        #3;
        check_all_zero("reset");
        @(posedge clk_in);
        #3;
        reset = 1'b0;

        // Stray bytes in IDLE, then a byte coincident with row_start: none may be written.
        step(0, 0, 1, 8'hEE);
        step(0, 0, 1, 8'hEF);
        step(1, 3, 1, 8'hDD);
        // Top-half row 3: expect 0x301=A1, 0x300=B2.
        step(0, 0, 1, 8'hA1);
        step(0, 0, 0, 8'h00);
        step(0, 0, 1, 8'hB2);
        // Bottom-half row 19: expect 0x303=5C, 0x302=7D.
        step(1, 19, 0, 8'h00);
        step(0, 0, 1, 8'h5C);
        step(0, 0, 1, 8'h7D);

        // Full row 3 with random gaps, ending at 0x3FC with row_done.
        step(1, 3, 0, 8'h00);
        guard = 0;
        while (m_active && guard < 4000) begin
            step(0, 0, ($urandom_range(0, 2) != 0), 8'($urandom));
            guard++;
        end
        check("full_row_completed", 32'(m_active), 32'(0));
        step(0, 0, 1, 8'h99);

        // Abort: 10 bytes of row 3, then row 0 from scratch.
        step(1, 3, 0, 8'h00);
        for (int i = 0; i < 10; i++) step(0, 0, 1, 8'($urandom));
        step(1, 0, 0, 8'h00);
        for (int i = 0; i < TOTAL; i++) step(0, 0, 1, 8'($urandom));
        check("abort_row_completed", 32'(m_active), 32'(0));

        // Reset after 5 bytes: everything drops immediately, later bytes ignored.
        step(1, 7, 0, 8'h00);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 8'($urandom));
        @(negedge clk_in);
        #2;
        reset    = 1'b1;
        m_active = 0;
        #1;
        check_all_zero("midreset");
        @(posedge clk_in);
        #2;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) step(0, 0, 1, 8'($urandom));

        // Randomized rows with gaps, occasional aborts and stray row_start+data collisions.
        for (int r = 0; r < 6; r++) begin
            step(1, int'($urandom_range(0, 31)), ($urandom_range(0, 1) == 1), 8'($urandom));
            guard = 0;
            while (m_active && guard < 4000) begin
                if ($urandom_range(0, 199) == 0)
                    step(1, int'($urandom_range(0, 31)), ($urandom_range(0, 1) == 1), 8'($urandom));
                else
                    step(0, 0, ($urandom_range(0, 3) != 0), 8'($urandom));
                guard++;
            end
            check("rand_row_completed", 32'(m_active), 32'(0));
            for (int i = 0; i < 3; i++) step(0, 0, ($urandom_range(0, 1) == 1), 8'($urandom));
        end

        step(0, 0, 0, 8'h00);
        @(negedge clk_in);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
